// File: rtl/eq_cmp_pkg.sv
// Shared types and constants for the equality-compare sequencer.
// The EQ_DEBOUNCE_EN macro (button debounce filter) is consumed by btn_pulse.
package eq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    A_LOADED = 2'd1,
    COMPARE  = 2'd2,
    SHOW     = 2'd3
  } state_t;

  // Bit positions of the two board buttons on the btn bus
  localparam int BTN_LOAD  = 0;
  localparam int BTN_CLEAR = 1;

endpackage

// File: rtl/eq_cmp_ctrl_btn_pulse.sv
// btn_pulse: one board button -> one-cycle strobe per press.
// Two-flop synchronizer, optional stability filter (EQ_DEBOUNCE_EN),
// then rising-edge detect. A held button produces exactly one pulse.
module btn_pulse #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

`ifdef EQ_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic sync1_reg;
  logic sync2_reg;
  logic level;
  logic level_d_reg;

  // Bring the asynchronous button level into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    if (DB_EN) begin : g_db
      localparam int DB_W = $clog2(DB_CYCLES + 1);
      logic [DB_W-1:0] db_cnt_reg;
      logic            filt_reg;

      // Accept a new level only after it has been seen DB_CYCLES cycles in a row
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          db_cnt_reg <= '0;
          filt_reg   <= 1'b0;
        end else if (sync2_reg == filt_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_W'(DB_CYCLES - 1)) begin
          db_cnt_reg <= '0;
          filt_reg   <= sync2_reg;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end

      assign level = filt_reg;
    end else begin : g_nodb
      assign level = sync2_reg;
    end
  endgenerate

  // Remember the previous clean level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_d_reg <= 1'b0;
    else          level_d_reg <= level;
  end

  assign pulse = level & ~level_d_reg;

endmodule

// File: rtl/eq_cmp_ctrl.sv
// eq_cmp_ctrl: sequencer for the 4-bit equality comparator.
// Steps operand A then B from the switches into the comparator, samples its
// equal flag, holds the result and keeps saturating compare/match counters.
// Build option: EQ_DEBOUNCE_EN adds a DB_CYCLES button filter in btn_pulse.
module eq_cmp_ctrl
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       btn,
  input  logic             eq_in,
  output logic [WIDTH-1:0] op_data,
  output logic             load_a,
  output logic             load_b,
  output logic             result_valid,
  output logic             match,
  output logic [CNT_W-1:0] compare_cnt,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] pulse_vec;
  logic       ld_p;
  logic       clr_p;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn_pulse (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn[gi]),
        .pulse   (pulse_vec[gi])
      );
    end
  endgenerate

  assign ld_p  = pulse_vec[BTN_LOAD];
  assign clr_p = pulse_vec[BTN_CLEAR];

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_data_reg, op_data_next;
  logic             load_a_reg, load_a_next;
  logic             load_b_reg, load_b_next;
  logic             result_valid_reg, result_valid_next;
  logic             match_reg, match_next;
  logic [CNT_W-1:0] compare_cnt_reg, compare_cnt_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;

  // State and every output are registered together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      op_data_reg      <= '0;
      load_a_reg       <= 1'b0;
      load_b_reg       <= 1'b0;
      result_valid_reg <= 1'b0;
      match_reg        <= 1'b0;
      compare_cnt_reg  <= '0;
      match_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      op_data_reg      <= op_data_next;
      load_a_reg       <= load_a_next;
      load_b_reg       <= load_b_next;
      result_valid_reg <= result_valid_next;
      match_reg        <= match_next;
      compare_cnt_reg  <= compare_cnt_next;
      match_cnt_reg    <= match_cnt_next;
    end
  end

  // Next state and next outputs; CLEAR takes priority over LOAD
  always_comb begin
    state_next        = state_reg;
    op_data_next      = '0;
    load_a_next       = 1'b0;
    load_b_next       = 1'b0;
    result_valid_next = result_valid_reg;
    match_next        = match_reg;
    compare_cnt_next  = compare_cnt_reg;
    match_cnt_next    = match_cnt_reg;

    if (clr_p) begin
      if (state_reg == IDLE) begin
        compare_cnt_next = '0;
        match_cnt_next   = '0;
      end else begin
        // Abort: any in-flight compare is dropped, counters are kept
        state_next        = IDLE;
        result_valid_next = 1'b0;
        match_next        = 1'b0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (ld_p) begin
            load_a_next  = 1'b1;
            op_data_next = sw;
            state_next   = A_LOADED;
          end
        end
        A_LOADED: begin
          // The comparator captures B at the edge ending the load_b cycle,
          // so eq_in is only meaningful one cycle later in COMPARE.
          if (load_b_reg) begin
            state_next = COMPARE;
          end else if (ld_p) begin
            load_b_next  = 1'b1;
            op_data_next = sw;
          end
        end
        COMPARE: begin
          match_next        = eq_in;
          result_valid_next = 1'b1;
          if (compare_cnt_reg != CNT_MAX) compare_cnt_next = compare_cnt_reg + 1'b1;
          if (eq_in && (match_cnt_reg != CNT_MAX)) match_cnt_next = match_cnt_reg + 1'b1;
          state_next = SHOW;
        end
        SHOW: begin
          if (ld_p) begin
            result_valid_next = 1'b0;
            load_a_next       = 1'b1;
            op_data_next      = sw;
            state_next        = A_LOADED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign op_data      = op_data_reg;
  assign load_a       = load_a_reg;
  assign load_b       = load_b_reg;
  assign result_valid = result_valid_reg;
  assign match        = match_reg;
  assign compare_cnt  = compare_cnt_reg;
  assign match_cnt    = match_cnt_reg;

endmodule

// File: tb/tb_eq_cmp_ctrl.sv
// Bench for eq_cmp_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a transaction-level reference model.
// Honours EQ_DEBOUNCE_EN for press latency and the glitch scenario.
module tb_eq_cmp_ctrl;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 3;
  localparam int DB      = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EQ_DEBOUNCE_EN
  localparam int LAT      = 3 + DB;  // button set -> strobe visible
  localparam int MIN_HOLD = DB;      // shortest press that registers
  localparam int HOLD     = DB + 4;
  localparam int REL      = DB + 4;
`else
  localparam int LAT      = 3;
  localparam int MIN_HOLD = 1;
  localparam int HOLD     = 3;
  localparam int REL      = 4;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] sw;
  logic [1:0]       btn;
  logic             eq_in;
  logic [WIDTH-1:0] op_data;
  logic             load_a, load_b, result_valid, match;
  logic [CNT_W-1:0] compare_cnt, match_cnt;

  eq_cmp_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DB_CYCLES(DB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw           (sw),
    .btn          (btn),
    .eq_in        (eq_in),
    .op_data      (op_data),
    .load_a       (load_a),
    .load_b       (load_b),
    .result_valid (result_valid),
    .match        (match),
    .compare_cnt  (compare_cnt),
    .match_cnt    (match_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in comparator core: operand registers written by the strobes
  logic [WIDTH-1:0] cmp_a, cmp_b;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_a <= '0;
      cmp_b <= '0;
    end else begin
      if (load_a) cmp_a <= op_data;
      if (load_b) cmp_b <= op_data;
    end
  end
  assign eq_in = (cmp_a == cmp_b);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int la_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: ph 0=idle 1=A held 2=B strobed 3=comparing 4=showing
  int ld_q[$];
  int clr_q[$];
  int ph;
  int m_a, m_b;
  int e_la, e_lb, e_op, e_rv, e_m, e_cc, e_mc;
  bit m_known;

  task automatic model_reset();
    ph = 0; m_a = 0; m_b = 0;
    e_la = 0; e_lb = 0; e_op = 0; e_rv = 0; e_m = 0; e_cc = 0; e_mc = 0;
    m_known = 1'b1;
    ld_q.delete();
    clr_q.delete();
  endtask

  task automatic model_step(input bit ld, input bit clr, input int swv);
    e_la = 0; e_lb = 0; e_op = 0;
    if (clr) begin
      if (ph == 0) begin
        e_cc = 0; e_mc = 0;
      end else begin
        ph = 0; e_rv = 0; e_m = 0; m_known = 1'b1;
      end
    end else begin
      case (ph)
        0: if (ld) begin e_la = 1; e_op = swv; m_a = swv; ph = 1; end
        1: if (ld) begin e_lb = 1; e_op = swv; m_b = swv; ph = 2; end
        2: ph = 3;
        3: begin
          e_m = (m_a == m_b) ? 1 : 0;
          e_rv = 1; m_known = 1'b1;
          if (e_cc < CNT_MAX) e_cc++;
          if (e_m == 1 && e_mc < CNT_MAX) e_mc++;
          ph = 4;
        end
        default: if (ld) begin e_rv = 0; e_la = 1; e_op = swv; m_a = swv; ph = 1; m_known = 1'b0; end
      endcase
    end
  endtask

  // Advance the model on each edge, compare on the falling edge
  initial begin
    bit ld, clr;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n) begin
        ld = 1'b0; clr = 1'b0;
        while (ld_q.size() > 0 && ld_q[0] <= cyc) begin ld = (ld_q[0] == cyc); void'(ld_q.pop_front()); end
        while (clr_q.size() > 0 && clr_q[0] <= cyc) begin clr = (clr_q[0] == cyc); void'(clr_q.pop_front()); end
        model_step(ld, clr, int'(sw));
      end
      @(negedge clk);
      if (load_a) la_seen++;
      check("load_a", load_a, e_la);
      check("load_b", load_b, e_lb);
      check("op_data", op_data, e_op);
      check("result_valid", result_valid, e_rv);
      if (m_known) check("match", match, e_m);
      check("compare_cnt", compare_cnt, e_cc);
      check("match_cnt", match_cnt, e_mc);
    end
  end

  // One button press: set at a falling edge, hold, release, settle
  task automatic press(input logic [1:0] mask, input logic [WIDTH-1:0] val, input int hold);
    @(negedge clk);
    sw  = val;
    btn = mask;
    if (hold >= MIN_HOLD) begin
      if (mask[0]) ld_q.push_back(cyc + LAT);
      if (mask[1]) clr_q.push_back(cyc + LAT);
    end
    repeat (hold) @(negedge clk);
    btn = 2'b00;
    repeat (REL) @(negedge clk);
    $display("press mask=%b sw=%h hold=%0d -> rv=%0d match=%0d cc=%0d mc=%0d",
             mask, val, hold, result_valid, match, compare_cnt, match_cnt);
  endtask

  task automatic do_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    press(2'b01, a, HOLD);
    press(2'b01, b, HOLD);
  endtask

  initial begin
    int r, hold;
    logic [1:0] mask;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] last_val;
    reset_n = 1'b0;
    sw  = '0;
    btn = 2'b00;
    #1;
    check("rst_load_a", load_a, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_compare_cnt", compare_cnt, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Equal operands A,A
    do_compare(4'hA, 4'hA);
    check("t2_match", match, 1);
    check("t2_rv", result_valid, 1);
    check("t2_cc", compare_cnt, 1);
    check("t2_mc", match_cnt, 1);

    // Unequal operands from SHOW
    do_compare(4'h3, 4'h5);
    check("t3_match", match, 0);
    check("t3_cc", compare_cnt, 2);
    check("t3_mc", match_cnt, 1);

    // Three more to reach five compares, then async reset mid-SHOW
    do_compare(4'h1, 4'h1);
    do_compare(4'h7, 4'h2);
    do_compare(4'hF, 4'hF);
    check("t1_cc_before", compare_cnt, 5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t1_load_a", load_a, 0);
    check("t1_op_data", op_data, 0);
    check("t1_rv", result_valid, 0);
    check("t1_match", match, 0);
    check("t1_cc", compare_cnt, 0);
    check("t1_mc", match_cnt, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // LOAD+CLEAR together in A_LOADED aborts; CLEAR in IDLE zeroes counters
    do_compare(4'h6, 4'h6);
    press(2'b01, 4'h4, HOLD);
    press(2'b11, 4'h4, HOLD);
    check("t4_load_b", load_b, 0);
    check("t4_rv", result_valid, 0);
    check("t4_cc_kept", compare_cnt, 1);
    press(2'b10, 4'h0, HOLD);
    check("t4_cc_clr", compare_cnt, 0);
    check("t4_mc_clr", match_cnt, 0);

    // Saturation: more matching compares than the counters can hold
    for (int i = 0; i < CNT_MAX + 2; i++) do_compare(4'(i), 4'(i));
    check("t5_cc_sat", compare_cnt, CNT_MAX);
    check("t5_mc_sat", match_cnt, CNT_MAX);
    press(2'b10, 4'h0, HOLD);
    press(2'b10, 4'h0, HOLD);

`ifdef EQ_DEBOUNCE_EN
    // Short glitch must not strobe; a full hold strobes exactly once
    la_seen = 0;
    press(2'b01, 4'h9, 10);
    check("t6_glitch", la_seen, 0);
    press(2'b01, 4'h9, DB + 4);
    check("t6_hold", la_seen, 1);
    press(2'b10, 4'h0, HOLD);
`endif

    // Random button traffic
    last_val = '0;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      mask = (r < 7) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11);
      val  = ($urandom_range(0, 1) == 1) ? last_val : 4'($urandom);
      last_val = val;
`ifdef EQ_DEBOUNCE_EN
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, DB - 1)) : int'($urandom_range(DB, DB + 6));
`else
      hold = int'($urandom_range(1, 4));
`endif
      press(mask, val, hold);
    end

    repeat (LAT + REL) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
